// File: rtl/tick_scheduler_if.sv
// Bundles the per-channel configuration inputs and the tick/ack/busy
// outputs of the tick scheduler. The scheduler takes the slave side and the
// environment driving it takes the master side.
interface tick_scheduler_if #(
    parameter int NUM_CH  = 4,
    parameter int SPEED_W = 21
);
    logic [NUM_CH*SPEED_W-1:0] speed;
    logic [NUM_CH-1:0]         cfg_req;
    logic [NUM_CH-1:0]         enable;
    logic [NUM_CH-1:0]         cfg_ack;
    logic [NUM_CH-1:0]         tick;
    logic                      busy;

    modport master (
        output speed, cfg_req, enable,
        input  cfg_ack, tick, busy
    );

    modport slave (
        input  speed, cfg_req, enable,
        output cfg_ack, tick, busy
    );
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel tick generator. Each channel ticks once every
// BASE_SPEED/speed clock cycles. A single restoring divider is shared
// round-robin between channels: a reconfigure request is queued as pending,
// the arbiter grants one channel at a time, the divider produces one
// quotient bit per cycle, and the new period is committed in one cycle.
module tick_scheduler #(
    parameter int BASE_SPEED = 50000000,
    parameter int NUM_CH     = 4
) (
    input logic             clk,
    input logic             reset_button,
    tick_scheduler_if.slave bus
);
    localparam int SPEED_W = $clog2(1000000) + 1;
    localparam int CNT_W   = $clog2(BASE_SPEED) + 1;
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STEP_W  = $clog2(CNT_W) + 1;

    localparam logic [CNT_W-1:0] BASE_V = CNT_W'(BASE_SPEED);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    // Scheduler / divider state
    logic [1:0]         state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_CH-1:0]  pending;
    logic               again;      // request for the granted channel arrived mid-service
    logic [STEP_W-1:0]  step;
    logic [SPEED_W-1:0] divisor;
    logic [CNT_W-1:0]   dvd;
    logic [SPEED_W-1:0] rem;
    logic [CNT_W-1:0]   quot;

    // Per-channel tick state
    logic [CNT_W-1:0]   period  [NUM_CH];
    logic [CNT_W-1:0]   counter [NUM_CH];
    logic [NUM_CH-1:0]  tick_q;

    // Combinational helpers
    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   cand;
    logic [SPEED_W:0]   rem_shift;
    logic               rem_ge;
    logic [SPEED_W-1:0] rem_next;
    logic [CNT_W-1:0]   new_period;
    logic [NUM_CH-1:0]  commit_ch;
    logic [CNT_W-1:0]   per_eff  [NUM_CH];
    logic [CNT_W-1:0]   cnt_base [NUM_CH];

    // Round-robin arbiter: lowest pending index at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(rr_ptr) + k >= NUM_CH) cand = IDX_W'(int'(rr_ptr) + k - NUM_CH);
            else                            cand = IDX_W'(int'(rr_ptr) + k);
            if (!arb_found && pending[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem, dvd[CNT_W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor});
    assign rem_next  = rem_ge ? SPEED_W'(rem_shift - {1'b0, divisor}) : rem_shift[SPEED_W-1:0];

    // Period to commit: 0 Hz silences the channel, a zero quotient clamps to 1.
    always_comb begin
        if (divisor == '0)    new_period = '0;
        else if (quot == '0)  new_period = CNT_W'(1);
        else                  new_period = quot;
    end

    // The commit cycle counts as cycle 0 of the new period, so the counter
    // restarts from 0 against the new period on the commit edge.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            commit_ch[i] = (state == COMMIT) && (grant == IDX_W'(i));
            per_eff[i]   = commit_ch[i] ? new_period : period[i];
            cnt_base[i]  = commit_ch[i] ? '0 : counter[i];
        end
    end

    // Scheduler FSM and iterative divider datapath.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset_button) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            step    <= '0;
            divisor <= '0;
            dvd     <= '0;
            rem     <= '0;
            quot    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant   <= arb_idx;
                        divisor <= bus.speed[arb_idx*SPEED_W +: SPEED_W];
                        dvd     <= BASE_V;
                        rem     <= '0;
                        quot    <= '0;
                        step    <= '0;
                        state   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    dvd  <= {dvd[CNT_W-2:0], 1'b0};
                    rem  <= rem_next;
                    quot <= {quot[CNT_W-2:0], rem_ge};
                    step <= step + 1'b1;
                    if (step == STEP_W'(CNT_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    rr_ptr <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending requests: set by cfg_req, cleared at the channel's commit unless re-requested.
    always_ff @(posedge clk) begin
        if (reset_button) begin
            pending <= '0;
            again   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit_ch[i]) pending[i] <= again | bus.cfg_req[i];
                else              pending[i] <= pending[i] | bus.cfg_req[i];
            end
            if (state == COMMIT)
                again <= 1'b0;
            else if (state == DIVIDE && bus.cfg_req[grant])
                again <= 1'b1;
        end
    end

    // Per-channel period registers, free-running counters and registered ticks.
    always_ff @(posedge clk) begin
        if (reset_button) begin
            // NOTE: period/counter are small flop arrays, not RAM, so they are
            // reset explicitly to leave every channel silent after reset.
            for (int i = 0; i < NUM_CH; i++) begin
                period[i]  <= '0;
                counter[i] <= '0;
            end
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (commit_ch[i]) period[i] <= new_period;
                if (bus.enable[i] && per_eff[i] != '0) begin
                    if (cnt_base[i] == per_eff[i] - 1'b1) begin
                        counter[i] <= '0;
                        tick_q[i]  <= 1'b1;
                    end else begin
                        counter[i] <= cnt_base[i] + 1'b1;
                        tick_q[i]  <= 1'b0;
                    end
                end else begin
                    counter[i] <= '0;
                    tick_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign bus.tick    = tick_q;
    assign bus.cfg_ack = commit_ch;
    // Busy also covers the grant cycle, when a request is waiting in IDLE.
    assign bus.busy    = (state != IDLE) || (|pending);

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with BASE_SPEED=1000, NUM_CH=4 (CNT_W=11).
// Cycle c of a case is the interval after the c-th clock edge following the
// cycle in which cfg_req is driven (cycle 0).
module tb_tick_scheduler;
    localparam int NUM_CH  = 4;
    localparam int SPEED_W = 21;

    logic clk = 1'b0;
    logic reset_button;
    int   n_tests = 0;
    int   n_fail  = 0;

    tick_scheduler_if #(.NUM_CH(NUM_CH), .SPEED_W(SPEED_W)) bus ();

    tick_scheduler #(.BASE_SPEED(1000), .NUM_CH(NUM_CH)) dut (
        .clk          (clk),
        .reset_button (reset_button),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_speed(input int ch, input int hz);
        bus.speed[ch*SPEED_W +: SPEED_W] = SPEED_W'(hz);
    endtask

    task automatic do_reset();
        reset_button = 1'b1;
        bus.cfg_req  = '0;
        step();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset tick", 32'(bus.tick), 32'd0);
        check("reset ack",  32'(bus.cfg_ack), 32'd0);
        step();
        reset_button = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_c [NUM_CH];
        int per_c [NUM_CH];
        logic [3:0] exp_ack;
        logic [3:0] exp_tick;

        reset_button = 1'b1;
        bus.speed    = '0;
        bus.cfg_req  = '0;
        bus.enable   = '0;
        step();
        do_reset();

        // Case A: ch0 at 100 Hz -> period 10, ack at 13, busy 1..13, ticks 23, 33, 43
        set_speed(0, 100);
        bus.enable  = 4'b0001;
        bus.cfg_req = 4'b0001;
        for (int c = 1; c <= 45; c++) begin
            step();
            if (c == 1) bus.cfg_req = '0;
            check($sformatf("A ack c%0d", c),  32'(bus.cfg_ack), (c == 13) ? 32'd1 : 32'd0);
            check($sformatf("A busy c%0d", c), 32'(bus.busy), (c <= 13) ? 32'd1 : 32'd0);
            check($sformatf("A tick c%0d", c), 32'(bus.tick),
                  (c >= 23 && (c - 23) % 10 == 0) ? 32'd1 : 32'd0);
        end

        // Case B: all four channels requested together, served in order 0..3
        do_reset();
        set_speed(0, 250);
        set_speed(1, 200);
        set_speed(2, 125);
        set_speed(3, 100);
        ack_c = '{13, 26, 39, 52};
        per_c = '{4, 5, 8, 10};
        bus.enable  = 4'b1111;
        bus.cfg_req = 4'b1111;
        for (int c = 1; c <= 80; c++) begin
            step();
            if (c == 1) bus.cfg_req = '0;
            exp_ack  = '0;
            exp_tick = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (c == ack_c[ch]) exp_ack[ch] = 1'b1;
                if (c > ack_c[ch] && (c - ack_c[ch]) % per_c[ch] == 0) exp_tick[ch] = 1'b1;
            end
            check($sformatf("B ack c%0d", c),  32'(bus.cfg_ack), 32'(exp_ack));
            check($sformatf("B tick c%0d", c), 32'(bus.tick), 32'(exp_tick));
            check($sformatf("B busy c%0d", c), 32'(bus.busy), (c <= 52) ? 32'd1 : 32'd0);
        end

        // Case C: ch2 at 0 Hz goes silent; then 3000 Hz clamps to period 1
        set_speed(2, 0);
        bus.cfg_req = 4'b0100;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 1) bus.cfg_req = '0;
            check($sformatf("C0 ack c%0d", c), 32'(bus.cfg_ack), (c == 13) ? 32'h4 : 32'd0);
            if (c >= 14) check($sformatf("C0 tick2 c%0d", c), 32'(bus.tick[2]), 32'd0);
        end
        set_speed(2, 3000);
        bus.cfg_req = 4'b0100;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1) bus.cfg_req = '0;
            check($sformatf("C1 ack c%0d", c), 32'(bus.cfg_ack), (c == 13) ? 32'h4 : 32'd0);
            if (c >= 13) check($sformatf("C1 tick2 c%0d", c), 32'(bus.tick[2]),
                               (c >= 14) ? 32'd1 : 32'd0);
        end

        // Case D: ch1 period 10, enable low during cycles 30..36, restart at 37
        set_speed(1, 100);
        bus.cfg_req = 4'b0010;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (c == 1) bus.cfg_req = '0;
            check($sformatf("D ack c%0d", c), 32'(bus.cfg_ack), (c == 13) ? 32'h2 : 32'd0);
            if (c >= 14) check($sformatf("D tick1 c%0d", c), 32'(bus.tick[1]),
                               (c == 23 || c == 47 || c == 57) ? 32'd1 : 32'd0);
            if (c == 30) bus.enable[1] = 1'b0;
            if (c == 37) bus.enable[1] = 1'b1;
        end

        // Case E: reset during ch3's DIVIDE (with a colliding cfg_req) aborts everything
        set_speed(3, 100);
        bus.cfg_req = 4'b1000;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) bus.cfg_req = '0;
            check($sformatf("E ack c%0d", c),  32'(bus.cfg_ack), 32'd0);
            check($sformatf("E busy c%0d", c), 32'(bus.busy), 32'd1);
        end
        reset_button = 1'b1;
        bus.cfg_req  = 4'b0010;
        step();
        reset_button = 1'b0;
        bus.cfg_req  = '0;
        check("E busy after reset", 32'(bus.busy), 32'd0);
        check("E ack after reset",  32'(bus.cfg_ack), 32'd0);
        check("E tick after reset", 32'(bus.tick), 32'd0);
        for (int c = 7; c <= 30; c++) begin
            step();
            check($sformatf("E idle ack c%0d", c),  32'(bus.cfg_ack), 32'd0);
            check($sformatf("E idle tick c%0d", c), 32'(bus.tick), 32'd0);
            check($sformatf("E idle busy c%0d", c), 32'(bus.busy), 32'd0);
        end
        bus.cfg_req = 4'b1111;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c == 1) bus.cfg_req = '0;
            check($sformatf("E rr ack c%0d", c), 32'(bus.cfg_ack), (c == 13) ? 32'h1 : 32'd0);
        end

        // Case F: ch0 re-requested mid-DIVIDE with 50 Hz -> two acks, final period 20
        do_reset();
        set_speed(0, 100);
        bus.enable  = 4'b0001;
        bus.cfg_req = 4'b0001;
        for (int c = 1; c <= 70; c++) begin
            step();
            if (c == 1 || c == 6) bus.cfg_req = '0;
            check($sformatf("F ack c%0d", c),  32'(bus.cfg_ack),
                  (c == 13 || c == 26) ? 32'h1 : 32'd0);
            check($sformatf("F busy c%0d", c), 32'(bus.busy), (c <= 26) ? 32'd1 : 32'd0);
            check($sformatf("F tick c%0d", c), 32'(bus.tick),
                  (c == 23 || c == 46 || c == 66) ? 32'h1 : 32'd0);
            if (c == 5) begin
                set_speed(0, 50);
                bus.cfg_req = 4'b0001;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter BASE_SPEED, default 50000000, SHALL be the clk frequency in Hz.
REQ-002 Parameter NUM_CH, default 4, SHALL be the number of tick channels (1..8).
REQ-003 Derived widths SHALL be SPEED_W = $clog2(1000000)+1 (21) and CNT_W = $clog2(BASE_SPEED)+1.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset_button  input  1  synchronous, active-high reset.
REQ-006 speed  input  NUM_CH*SPEED_W  requested tick rate in Hz; channel i occupies bits [i*SPEED_W +: SPEED_W].
REQ-007 cfg_req  input  NUM_CH  per-channel reconfigure request; sampled each cycle.
REQ-008 enable  input  NUM_CH  per-channel run enable.
REQ-009 cfg_ack  output  NUM_CH  one-cycle pulse when the channel's new period takes effect.
REQ-010 tick  output  NUM_CH  one-cycle tick pulse per channel period.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 The block SHALL hold one shared iterative divider computing period = BASE_SPEED / speed, one quotient bit per cycle, CNT_W cycles per division.
REQ-013 Per channel, cfg_req high in a cycle SHALL set pending[i] at that clock edge; pending[i] SHALL clear only at that channel's COMMIT.
REQ-014 cfg_req for a channel already pending or in service SHALL set pending again, causing one further service after the current one; no request is lost.
REQ-015 FSM states SHALL be IDLE, DIVIDE, COMMIT.
REQ-016 IDLE: if any pending, grant the lowest index at or above rr_ptr (wrapping modulo NUM_CH), latch that channel's speed this cycle, load the divider, go to DIVIDE; else stay.
REQ-017 DIVIDE SHALL last exactly CNT_W cycles, then go to COMMIT.
REQ-018 COMMIT SHALL last one cycle: write period[grant], clear pending[grant], clear that channel's counter, pulse cfg_ack[grant], set rr_ptr = (grant+1) mod NUM_CH, return to IDLE.
REQ-019 Latency with an idle FSM and no other pending: cfg_req sampled in cycle 0 -> cfg_ack high in cycle CNT_W+2; consecutive services SHALL be spaced CNT_W+2 cycles.
REQ-020 speed == 0 SHALL yield period 0; the channel then produces no ticks.
REQ-021 speed > BASE_SPEED (quotient 0) SHALL clamp period to 1, ticking every cycle.
REQ-022 The quotient SHALL be truncated (floor) and stored in CNT_W bits without overflow.
REQ-023 Each channel SHALL keep a CNT_W-bit counter that advances only while enable[i]=1 and period[i]!=0.
REQ-024 When it advances, tick[i] SHALL be registered high for one cycle when the counter equals period-1, and the counter SHALL then wrap to 0.
REQ-025 With enable held high, the first tick[i] SHALL occur exactly period[i] cycles after the cfg_ack[i] cycle.
REQ-026 Subsequent ticks SHALL follow every period[i] cycles.
REQ-027 enable[i]=0 SHALL hold counter[i] at 0 and tick[i] at 0; re-enable SHALL restart the count from 0.
REQ-028 Channels SHALL keep ticking on their old period until their own COMMIT; the divider busy on one channel SHALL not disturb the others.
REQ-029 At most one cfg_ack bit SHALL be high in any cycle.

Reset
REQ-030 With reset_button high at an edge, the block SHALL clear state to IDLE, rr_ptr to 0, and all pending, period, counter, divider registers to 0.
REQ-031 With reset_button high at an edge, the block SHALL drive tick, cfg_ack and busy to 0 on the following cycle.
REQ-032 Reset SHALL take priority over every other event, including a cfg_req in the same cycle and a COMMIT in progress.
REQ-033 Reset mid-DIVIDE SHALL abort the division with no cfg_ack and no period update.
REQ-034 After reset, all channels SHALL be silent (period 0) until reconfigured.

Verification (bench: BASE_SPEED=1000, NUM_CH=4, CNT_W=11)
REQ-035 Bench case: speed0=100, cfg_req[0] pulse in cycle 0, enable[0]=1 -> cfg_ack[0] in cycle 13, busy high cycles 1-13, ticks at cycles 23, 33, 43...
REQ-036 Bench case: speed=250/200/125/100 on ch0-3, cfg_req=4'b1111 in one cycle -> acks in order ch0,1,2,3 at cycles 13, 26, 39, 52 -> periods 4, 5, 8, 10.
REQ-037 Bench case: ch2 speed=0 -> ack, no tick ever -> then speed=3000 reconfigure -> tick[2] high every cycle after ack.
REQ-038 Bench case: ch1 ticking at period 10, enable[1] low 7 cycles then high -> no ticks while low, next tick 10 cycles after re-enable.
REQ-039 Bench case: reset_button high during DIVIDE of ch3 -> no cfg_ack, busy 0 next cycle, all ticks stop, rr_ptr=0 (next 4'b1111 request served from ch0).
REQ-040 Bench case: cfg_req[0] re-pulsed during its own DIVIDE with new speed 50 -> two acks for ch0; final period 20.
